// File: rtl/ov7620_capture_front.sv
// OV7620 camera front end: oversamples the raw camera pins in the CLK domain, frames and decimates
// active pixels, and queues {linear SRAM address, luma} entries behind a valid/ready write port.
module ov7620_capture_front #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 240,
  parameter int ADDR_W      = 18,
  parameter int PIX_DECIM   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              PCLK,
  input  logic              HREF,
  input  logic              VSYNC_ov7620_L,
  input  logic [7:0]        Y_Data,
  input  logic              capture_en,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              capturing,
  output logic              frame_done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int PCNT_W = $clog2(H_ACTIVE + 1);
  localparam int LCNT_W = $clog2(V_ACTIVE + 1);
  localparam int DCNT_W = (PIX_DECIM > 1) ? $clog2(PIX_DECIM) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  // Write port: wr_valid means the FIFO head holds a pixel; an entry leaves on a
  // cycle where wr_valid & wr_ready are both high. Head address/data hold while stalled.

  logic [SYNC_STAGES-1:0] pclk_sr, href_sr, vs_sr;
  logic [7:0]             y_sr [SYNC_STAGES];
  logic                   pclk_d, href_d, vs_d;
  logic                   pclk_s, href_s, vs_s;
  logic [7:0]             y_s;
  logic                   pix_stb, href_fall, vs_fall, vs_rise;

  // Y_Data goes through the same depth as PCLK so the sampled luma lines up with the synced edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pclk_sr <= '0;
      href_sr <= '0;
      vs_sr   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) y_sr[i] <= '0;
      pclk_d  <= 1'b0;
      href_d  <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], PCLK};
      href_sr <= {href_sr[SYNC_STAGES-2:0], HREF};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], VSYNC_ov7620_L};
      y_sr[0] <= Y_Data;
      for (int i = 1; i < SYNC_STAGES; i++) y_sr[i] <= y_sr[i-1];
      pclk_d  <= pclk_s;
      href_d  <= href_s;
      vs_d    <= vs_s;
    end
  end

  assign pclk_s    = pclk_sr[SYNC_STAGES-1];
  assign href_s    = href_sr[SYNC_STAGES-1];
  assign vs_s      = vs_sr[SYNC_STAGES-1];
  assign y_s       = y_sr[SYNC_STAGES-1];
  assign pix_stb   = pclk_s & ~pclk_d & href_s;
  assign href_fall = ~href_s & href_d;
  assign vs_fall   = ~vs_s & vs_d;
  assign vs_rise   = vs_s & ~vs_d;

  logic [LCNT_W-1:0] line_cnt;
  logic [PCNT_W-1:0] pix_cnt;
  logic [DCNT_W-1:0] decim_cnt;
  logic [ADDR_W-1:0] addr, line_base;
  logic              frame_start, keep_stb, line_end;
  logic              push_vld;
  logic [ADDR_W-1:0] push_addr;
  logic [7:0]        push_data;
  logic              fifo_empty, fifo_full, pop, do_push, drop;

  assign keep_stb = (state == S_FRAME) && pix_stb && (decim_cnt == '0) &&
                    (pix_cnt < PCNT_W'(H_ACTIVE)) && (line_cnt < LCNT_W'(V_ACTIVE));
  assign line_end = (state == S_FRAME) && href_fall && (pix_cnt != '0);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (vs_fall && capture_en) begin
          state_n     = S_FRAME;
          frame_start = 1'b1;
        end
      end
      S_FRAME: begin
        if (vs_rise || (line_cnt == LCNT_W'(V_ACTIVE))) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        // The push register counts as queued data, so wait for it as well.
        if (fifo_empty && !push_vld) begin
          state_n    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign capturing = (state == S_FRAME);
  assign dbg_state = state;

  // The next line starts at line_base + H_ACTIVE; a short line leaves a gap in the address space.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      line_cnt  <= '0;
      pix_cnt   <= '0;
      decim_cnt <= '0;
      addr      <= '0;
      line_base <= '0;
    end else begin
      if (href_fall) begin
        decim_cnt <= '0;
      end else if (pix_stb) begin
        decim_cnt <= (decim_cnt == DCNT_W'(PIX_DECIM - 1)) ? '0 : decim_cnt + DCNT_W'(1);
      end
      if (frame_start) begin
        line_cnt  <= '0;
        pix_cnt   <= '0;
        addr      <= '0;
        line_base <= '0;
      end else if (keep_stb) begin
        addr    <= addr + ADDR_W'(1);
        pix_cnt <= pix_cnt + PCNT_W'(1);
      end else if (line_end) begin
        line_cnt  <= line_cnt + LCNT_W'(1);
        line_base <= line_base + H_STEP;
        addr      <= line_base + H_STEP;
        pix_cnt   <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      push_vld  <= 1'b0;
      push_addr <= '0;
      push_data <= '0;
    end else begin
      push_vld  <= keep_stb;
      push_addr <= addr;
      push_data <= y_s;
    end
  end

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign wr_valid   = !fifo_empty;
  assign pop        = wr_valid && wr_ready;
  assign do_push    = push_vld && (!fifo_full || pop);
  assign drop       = push_vld && fifo_full && !pop;
  assign wr_addr    = fifo_addr[rd_ptr];
  assign wr_data    = fifo_data[rd_ptr];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_addr[wr_ptr] <= push_addr;
        fifo_data[wr_ptr] <= push_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (frame_start) overflow <= 1'b0;
      else if (drop)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7620_capture_front.sv
// Bench for ov7620_capture_front: drives camera pin waveforms, predicts the SRAM write stream from
// line/pixel indices, and compares every accepted write plus framing/status outputs.
module tb_ov7620_capture_front;

  localparam int H   = 640;
  localparam int V   = 240;
  localparam int AW  = 18;
  localparam int DEC = 2;
  localparam int FD  = 4;
  localparam int SS  = 2;
  localparam int W   = AW + 8;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          PCLK = 1'b0;
  logic          HREF = 1'b0;
  logic          VSYNC_ov7620_L = 1'b1;
  logic [7:0]    Y_Data = 8'h00;
  logic          capture_en = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          capturing;
  logic          frame_done;
  logic          overflow;
  logic [1:0]    dbg_state;

  ov7620_capture_front #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_DECIM(DEC), .FIFO_DEPTH(FD), .SYNC_STAGES(SS)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .PCLK(PCLK), .HREF(HREF), .VSYNC_ov7620_L(VSYNC_ov7620_L),
    .Y_Data(Y_Data), .capture_en(capture_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .capturing(capturing), .frame_done(frame_done),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #4 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int pop_cnt = 0;
  int fd_cnt = 0;
  int rdy_mode = 0;    // 0 hold low, 1 hold high, 2 random
  bit m_active = 0;    // model: frame being captured
  int m_line = 0;      // model: stored lines so far
  int m_budget = -1;   // model: entries that still fit while the sink stalls (-1 unlimited)
  logic [W-1:0] exp_q[$];

  typedef struct {
    int n_lines;
    int n_pix;
    bit cap;
    bit drop_mid;
    int rdy;
    int exp_writes;
    bit exp_ovf;
    int exp_done;
  } scen_t;

  scen_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pclk_pix(input logic [7:0] y);
    Y_Data = y;
    PCLK = 1'b0;
    clk_n(3);
    PCLK = 1'b1;
    clk_n(3);
  endtask

  task automatic line(input int npix, input int ybase, input bit randy);
    int kept;
    int k;
    logic [7:0] y;
    logic [AW-1:0] a;
    kept = 0;
    HREF = 1'b1;
    clk_n(2);
    for (int i = 0; i < npix; i++) begin
      y = randy ? 8'($urandom_range(0, 255)) : 8'(ybase + i);
      if (i % DEC == 0) begin
        k = i / DEC;
        if (m_active && k < H && m_line < V) begin
          a = AW'(m_line * H + k);
          if (m_budget != 0) begin
            exp_q.push_back({a, y});
            if (m_budget > 0) m_budget--;
          end
          kept++;
        end
      end
      pclk_pix(y);
    end
    PCLK = 1'b0;
    clk_n(3);
    HREF = 1'b0;
    clk_n(6);
    if (m_active && kept > 0) begin
      m_line++;
      if (m_line >= V) m_active = 0;
    end
    check("capturing_after_line", capturing, m_active);
  endtask

  task automatic vs_low();
    VSYNC_ov7620_L = 1'b0;
    clk_n(6);
    m_active = capture_en;
    m_line = 0;
    check("capturing_at_frame_start", capturing, m_active);
  endtask

  task automatic vs_high();
    int n;
    VSYNC_ov7620_L = 1'b1;
    clk_n(6);
    m_active = 0;
    n = 0;
    while ((exp_q.size() != 0 || wr_valid) && n < 5000) begin
      clk_n(1);
      n++;
    end
    check("drain_in_time", n < 5000, 1);
    clk_n(4);
    check("capturing_after_frame", capturing, 0);
  endtask

  // ---------------- sink ready driver ----------------
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       wr_ready = 1'b0;
        1:       wr_ready = 1'b1;
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      if (RSTn && wr_valid && wr_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", wr_addr, '1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[W-1:8]);
          check("wr_data", wr_data, e[7:0]);
        end
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_when_drained", (exp_q.size() == 0) && !wr_valid, 1);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #480000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int fd0;
    int pc0;
    scen_t s;

    tbl[0] = '{n_lines: 2,   n_pix: 8,    cap: 1, drop_mid: 0, rdy: 1, exp_writes: 8,   exp_ovf: 0, exp_done: 1};
    tbl[1] = '{n_lines: 1,   n_pix: 1500, cap: 1, drop_mid: 0, rdy: 2, exp_writes: 640, exp_ovf: 0, exp_done: 1};
    tbl[2] = '{n_lines: 2,   n_pix: 8,    cap: 0, drop_mid: 0, rdy: 1, exp_writes: 0,   exp_ovf: 0, exp_done: 0};
    tbl[3] = '{n_lines: 2,   n_pix: 8,    cap: 1, drop_mid: 1, rdy: 2, exp_writes: 8,   exp_ovf: 0, exp_done: 1};
    tbl[4] = '{n_lines: 300, n_pix: 2,    cap: 1, drop_mid: 0, rdy: 1, exp_writes: 240, exp_ovf: 0, exp_done: 1};

    @(posedge CLK);
    #1;
    clk_n(3);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_capturing", capturing, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_state", dbg_state, 0);
    RSTn = 1'b1;
    clk_n(6);

    // Reset in the middle of a frame with three pixels queued.
    rdy_mode = 0;
    capture_en = 1'b1;
    vs_low();
    HREF = 1'b1;
    clk_n(2);
    for (int i = 0; i < 6; i++) pclk_pix(8'(8'h20 + i));
    PCLK = 1'b0;
    clk_n(6);
    check("pre_reset_queued", wr_valid, 1);
    fd0 = fd_cnt;
    RSTn = 1'b0;
    clk_n(2);
    check("midrst_wr_valid", wr_valid, 0);
    check("midrst_capturing", capturing, 0);
    RSTn = 1'b1;
    m_active = 0;
    clk_n(2);
    HREF = 1'b0;
    clk_n(6);
    rdy_mode = 1;
    line(8, 8'h30, 0);
    check("postrst_wr_valid", wr_valid, 0);
    check("postrst_no_frame_done", fd_cnt - fd0, 0);

    // Table-driven frames.
    for (int t = 0; t < 5; t++) begin
      s = tbl[t];
      rdy_mode = s.rdy;
      vs_high();
      fd0 = fd_cnt;
      pc0 = pop_cnt;
      capture_en = s.cap;
      vs_low();
      if (s.drop_mid) capture_en = 1'b0;
      for (int l = 0; l < s.n_lines; l++) line(s.n_pix, 8'h10, 0);
      vs_high();
      check("tbl_write_count", pop_cnt - pc0, s.exp_writes);
      check("tbl_overflow", overflow, s.exp_ovf);
      check("tbl_frame_done", fd_cnt - fd0, s.exp_done);
    end

    // Latency from the pin PCLK rise to wr_valid with an empty FIFO.
    rdy_mode = 0;
    capture_en = 1'b1;
    vs_low();
    HREF = 1'b1;
    clk_n(2);
    Y_Data = 8'hA5;
    PCLK = 1'b0;
    clk_n(3);
    PCLK = 1'b1;
    repeat (SS + 1) @(posedge CLK);
    @(negedge CLK);
    check("latency_early", wr_valid, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("latency_on_time", wr_valid, 1);
    @(posedge CLK);
    #1;
    clk_n(2);
    PCLK = 1'b0;
    clk_n(3);
    HREF = 1'b0;
    clk_n(6);
    exp_q.push_back({AW'(0), 8'hA5});
    m_line = 1;
    rdy_mode = 1;
    vs_high();

    // Sink stalled for 10 kept pixels: four entries held, the rest dropped.
    rdy_mode = 0;
    capture_en = 1'b1;
    vs_low();
    pc0 = pop_cnt;
    m_budget = 4;
    line(20, 8'h40, 0);
    check("ovf_set", overflow, 1);
    check("ovf_head_valid", wr_valid, 1);
    check("ovf_head_addr", wr_addr, 0);
    check("ovf_head_data", wr_data, 8'h40);
    clk_n(5);
    check("ovf_head_addr_stable", wr_addr, 0);
    check("ovf_head_data_stable", wr_data, 8'h40);
    m_budget = -1;
    rdy_mode = 1;
    line(8, 8'h80, 0);
    vs_high();
    check("ovf_write_count", pop_cnt - pc0, 8);
    check("ovf_sticky", overflow, 1);
    capture_en = 1'b1;
    vs_low();
    check("ovf_cleared_at_frame_start", overflow, 0);
    vs_high();

    // Random frames against the index-based model.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      int nl;
      fd0 = fd_cnt;
      capture_en = ($urandom_range(0, 3) != 0);
      s.cap = capture_en;
      vs_low();
      nl = $urandom_range(1, 5);
      for (int l = 0; l < nl; l++) line($urandom_range(0, 40), 0, 1);
      vs_high();
      check("rnd_overflow", overflow, 0);
      check("rnd_frame_done", fd_cnt - fd0, s.cap);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
